adder_result_collector: RTL and testbench

ADDER_RESULT_COLLECTOR -- requirements
Module: adder_result_collector

---
 rtl/adder_result_collector_pkg.sv | 17 +
 rtl/collector_frame_fifo.sv | 65 ++++++
 rtl/adder_result_collector.sv | 143 ++++++++++++++
 tb/tb_adder_result_collector.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_result_collector_pkg.sv
// Shared accelerator package: result-lane geometry and collector FSM states.
// Used by the adder-tree blocks and the result collector.
package adder_result_collector_pkg;

    // Number of bit-serial result lanes.
    localparam int ARC_LANES  = 8;
    // Serial beats per word (power of two).
    localparam int ARC_WORD_W = 32;
    // Frame buffer depth (power of two, >= 2).
    localparam int ARC_FRAMES = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } coll_state_t;

endpackage

// File: rtl/collector_frame_fifo.sv
// Frame FIFO: stores whole deserialized frames (all lanes side by side).
// Ports: i_push/i_push_data write, i_pop release head, o_head head frame,
//        o_full/o_empty status, o_count frames held.
module collector_frame_fifo #(
    parameter  int WIDTH = 256,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted when the head leaves in the
    // same cycle, so a frame arriving on the final handshake is kept.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/adder_result_collector.sv
// Deserializes bit-serial adder-tree results into per-lane words, buffers
// whole frames and streams them out one lane word per valid/ready handshake.
// Ports: in_valid/in_bits serial input; out_valid/out_ready/out_lane/out_data
//        word output; overflow sticky drop flag; frame_cnt buffered frames.
module adder_result_collector
    import adder_result_collector_pkg::*;
#(
    parameter  int LANES   = ARC_LANES,
    parameter  int WORD_W  = ARC_WORD_W,
    parameter  int FRAMES  = ARC_FRAMES,
    localparam int LANE_W  = $clog2(LANES),
    localparam int BEAT_W  = $clog2(WORD_W),
    localparam int CNT_W   = $clog2(FRAMES) + 1,
    localparam int FRAME_W = LANES * WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [LANES-1:0]  in_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_lane,
    output logic [WORD_W-1:0] out_data,
    output logic              overflow,
    output logic [CNT_W-1:0]  frame_cnt
);

    logic [WORD_W-1:0] r_shift [LANES];
    logic [BEAT_W-1:0] r_beat;
    logic              r_overflow;
    coll_state_t       r_state;
    logic              r_valid;
    logic [LANE_W-1:0] r_lane;

    logic [FRAME_W-1:0] w_frame;
    logic [FRAME_W-1:0] w_head;
    logic [WORD_W-1:0]  w_head_word [LANES];
    logic               w_complete;
    logic               w_pop;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;

    // w_frame is the shift-register contents after this beat, so the
    // completing beat's bits are part of the frame written at this edge.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_frame[g*WORD_W +: WORD_W] =
            {in_bits[g], r_shift[g][WORD_W-1:1]};
        assign w_head_word[g] = w_head[g*WORD_W +: WORD_W];
    end

    assign w_complete = in_valid && (r_beat == BEAT_W'(WORD_W - 1));
    assign w_pop      = (r_state == ST_SEND) && out_ready &&
                        (r_lane == LANE_W'(LANES - 1));
    assign w_drop     = w_complete && w_full && !w_pop;

    collector_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FRAMES)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_complete),
        .i_push_data (w_frame),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                r_shift[i] <= '0;
            end
            r_beat <= '0;
        end else if (in_valid) begin
            for (int i = 0; i < LANES; i++) begin
                r_shift[i] <= w_frame[i*WORD_W +: WORD_W];
            end
            // Power-of-two width: wraps to 0 even when the frame is dropped.
            r_beat <= r_beat + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_lane  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_SEND;
                        r_valid <= 1'b1;
                        r_lane  <= '0;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (r_lane == LANE_W'(LANES - 1)) begin
                            r_lane <= '0;
                            // Another frame remains after this pop, either
                            // already queued or arriving this cycle.
                            if (w_count > CNT_W'(1) || w_complete) begin
                                r_state <= ST_SEND;
                                r_valid <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_valid <= 1'b0;
                            end
                        end else begin
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_lane  <= '0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_lane  = r_lane;
    assign out_data  = r_valid ? w_head_word[r_lane] : '0;
    assign overflow  = r_overflow;
    assign frame_cnt = w_count;

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector: latency, gapped input,
// overflow, simultaneous push/pop, mid-frame reset and random back-pressure.
module tb_adder_result_collector;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_bits;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_lane;
    logic [31:0] out_data;
    logic        overflow;
    logic [1:0]  frame_cnt;

    int n_tests;
    int n_fail;
    int stab_err;

    logic [34:0] got_q [$];
    logic        hold_pend;
    logic [34:0] hold_val;

    adder_result_collector #(
        .LANES  (8),
        .WORD_W (32),
        .FRAMES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .out_data  (out_data),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records accepted words and checks hold stability at the falling edge.
    initial begin
        hold_pend = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend && {out_lane, out_data} !== hold_val) begin
                    stab_err++;
                end
                if (out_valid && out_ready) begin
                    got_q.push_back({out_lane, out_data});
                end
                hold_pend = out_valid && !out_ready;
                hold_val  = {out_lane, out_data};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [7:0] b);
        in_valid = v;
        in_bits  = b;
        tick();
    endtask

    task automatic send_frame(input logic [31:0] w [8]);
        logic [7:0] bits;
        for (int b = 0; b < 32; b++) begin
            for (int i = 0; i < 8; i++) begin
                bits[i] = w[i][b];
            end
            beat(1'b1, bits);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int maxc);
        int c;
        c = 0;
        while (got_q.size() < n && c < maxc) begin
            tick();
            c++;
        end
    endtask

    task automatic assert_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bits   = '0;
        out_ready = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        tick();
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic test_reset();
        n_tests++;
        if ({out_valid, out_lane, out_data, frame_cnt, overflow} !== '0) begin
            $display("FAIL reset_outputs got v=%b l=%0d d=%h c=%0d o=%b want all 0",
                     out_valid, out_lane, out_data, frame_cnt, overflow);
            n_fail++;
        end
        release_reset();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || frame_cnt !== 2'd0) begin
            $display("FAIL post_reset_idle got v=%b c=%0d want 0 0",
                     out_valid, frame_cnt);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        logic [31:0] w [8];
        for (int i = 0; i < 8; i++) w[i] = 32'hA5A5_0000 + i;
        out_ready = 1'b1;
        got_q.delete();
        send_frame(w);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || frame_cnt !== 2'd1) begin
            $display("FAIL basic_lat1 got v=%b c=%0d want v=0 c=1",
                     out_valid, frame_cnt);
            n_fail++;
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_lane !== 3'd0 ||
            out_data !== 32'hA5A5_0000) begin
            $display("FAIL basic_lat2 got v=%b l=%0d d=%h want 1 0 a5a50000",
                     out_valid, out_lane, out_data);
            n_fail++;
        end
        @(posedge clk);
        #1;
        wait_words(8, 40);
        n_tests++;
        if (got_q.size() != 8) begin
            $display("FAIL basic_count got %0d want 8", got_q.size());
            n_fail++;
        end
        for (int k = 0; k < 8 && k < got_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== {3'(k), w[k]}) begin
                $display("FAIL basic_word%0d got %h want %h",
                         k, got_q[k], {3'(k), w[k]});
                n_fail++;
            end
        end
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || frame_cnt !== 2'd0) begin
            $display("FAIL basic_idle got v=%b d=%h c=%0d want 0 0 0",
                     out_valid, out_data, frame_cnt);
            n_fail++;
        end
    endtask

    task automatic test_gapped();
        out_ready = 1'b1;
        got_q.delete();
        for (int c = 0; c < 64; c++) begin
            beat((c % 2) == 0, 8'hFF);
        end
        in_valid = 1'b0;
        wait_words(8, 40);
        repeat (10) tick();
        n_tests++;
        if (got_q.size() != 8) begin
            $display("FAIL gapped_count got %0d want 8", got_q.size());
            n_fail++;
        end
        for (int k = 0; k < 8 && k < got_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== {3'(k), 32'hFFFF_FFFF}) begin
                $display("FAIL gapped_word%0d got %h want %h",
                         k, got_q[k], {3'(k), 32'hFFFF_FFFF});
                n_fail++;
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] f1 [8];
        logic [31:0] f2 [8];
        logic [31:0] f3 [8];
        logic [31:0] f4 [8];
        logic [34:0] e;
        for (int i = 0; i < 8; i++) begin
            f1[i] = 32'h1111_0000 + i;
            f2[i] = 32'h2222_0000 + i;
            f3[i] = 32'h3333_0000 + i;
            f4[i] = 32'h4444_0000 + i;
        end
        out_ready = 1'b0;
        got_q.delete();
        send_frame(f1);
        send_frame(f2);
        n_tests++;
        if (frame_cnt !== 2'd2 || overflow !== 1'b0) begin
            $display("FAIL ovf_two got c=%0d o=%b want c=2 o=0",
                     frame_cnt, overflow);
            n_fail++;
        end
        send_frame(f3);
        n_tests++;
        if (frame_cnt !== 2'd2 || overflow !== 1'b1) begin
            $display("FAIL ovf_three got c=%0d o=%b want c=2 o=1",
                     frame_cnt, overflow);
            n_fail++;
        end
        out_ready = 1'b1;
        wait_words(16, 60);
        repeat (5) tick();
        n_tests++;
        if (got_q.size() != 16) begin
            $display("FAIL ovf_count got %0d want 16", got_q.size());
            n_fail++;
        end
        send_frame(f4);
        wait_words(24, 60);
        n_tests++;
        if (got_q.size() != 24) begin
            $display("FAIL ovf_recover_count got %0d want 24", got_q.size());
            n_fail++;
        end
        for (int k = 0; k < 24 && k < got_q.size(); k++) begin
            e = (k < 8)  ? {3'(k % 8), f1[k % 8]} :
                (k < 16) ? {3'(k % 8), f2[k % 8]} :
                           {3'(k % 8), f4[k % 8]};
            n_tests++;
            if (got_q[k] !== e) begin
                $display("FAIL ovf_word%0d got %h want %h", k, got_q[k], e);
                n_fail++;
            end
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            $display("FAIL ovf_sticky got %b want 1", overflow);
            n_fail++;
        end
    endtask

    task automatic test_simul_pop();
        logic [31:0] f1 [8];
        logic [31:0] f2 [8];
        logic [31:0] f3 [8];
        logic [7:0]  bits;
        logic [34:0] e;
        assert_reset();
        release_reset();
        n_tests++;
        if (overflow !== 1'b0) begin
            $display("FAIL simul_ovf_cleared got %b want 0", overflow);
            n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            f1[i] = 32'hC0DE_0010 + i;
            f2[i] = 32'hBEEF_0020 + i;
            f3[i] = 32'hCAFE_0030 + i;
        end
        send_frame(f1);
        send_frame(f2);
        for (int b = 0; b < 32; b++) begin
            for (int i = 0; i < 8; i++) bits[i] = f3[i][b];
            out_ready = (b >= 10 && b <= 16) || (b == 31);
            beat(1'b1, bits);
        end
        in_valid = 1'b0;
        n_tests++;
        if (frame_cnt !== 2'd2 || overflow !== 1'b0) begin
            $display("FAIL simul_state got c=%0d o=%b want c=2 o=0",
                     frame_cnt, overflow);
            n_fail++;
        end
        wait_words(24, 60);
        n_tests++;
        if (got_q.size() != 24) begin
            $display("FAIL simul_count got %0d want 24", got_q.size());
            n_fail++;
        end
        for (int k = 0; k < 24 && k < got_q.size(); k++) begin
            e = (k < 8)  ? {3'(k % 8), f1[k % 8]} :
                (k < 16) ? {3'(k % 8), f2[k % 8]} :
                           {3'(k % 8), f3[k % 8]};
            n_tests++;
            if (got_q[k] !== e) begin
                $display("FAIL simul_word%0d got %h want %h", k, got_q[k], e);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] f5 [8];
        logic [31:0] f6 [8];
        for (int i = 0; i < 8; i++) begin
            f5[i] = 32'hDEAD_0000 + i;
            f6[i] = 32'h0BAD_F000 + (i * 3);
        end
        out_ready = 1'b0;
        for (int b = 0; b < 17; b++) beat(1'b1, 8'h5A);
        assert_reset();
        n_tests++;
        if ({out_valid, out_lane, out_data, frame_cnt} !== '0) begin
            $display("FAIL rst_beat17 got v=%b l=%0d d=%h c=%0d want all 0",
                     out_valid, out_lane, out_data, frame_cnt);
            n_fail++;
        end
        release_reset();
        send_frame(f5);
        tick();
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_lane !== 3'd4 || out_data !== f5[4]) begin
            $display("FAIL rst_pending got v=%b l=%0d d=%h want 1 4 %h",
                     out_valid, out_lane, out_data, f5[4]);
            n_fail++;
        end
        assert_reset();
        n_tests++;
        if ({out_valid, out_lane, out_data, frame_cnt} !== '0) begin
            $display("FAIL rst_send got v=%b l=%0d d=%h c=%0d want all 0",
                     out_valid, out_lane, out_data, frame_cnt);
            n_fail++;
        end
        release_reset();
        out_ready = 1'b1;
        send_frame(f6);
        wait_words(8, 40);
        repeat (10) tick();
        n_tests++;
        if (got_q.size() != 8) begin
            $display("FAIL rst_clean_count got %0d want 8", got_q.size());
            n_fail++;
        end
        for (int k = 0; k < 8 && k < got_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== {3'(k), f6[k]}) begin
                $display("FAIL rst_clean_word%0d got %h want %h",
                         k, got_q[k], {3'(k), f6[k]});
                n_fail++;
            end
        end
    endtask

    task automatic test_random();
        logic [34:0] exp_q [$];
        logic        done;
        assert_reset();
        release_reset();
        stab_err = 0;
        done = 1'b0;
        fork
            begin
                logic [31:0] fw [8];
                for (int f = 0; f < 10; f++) begin
                    for (int i = 0; i < 8; i++) begin
                        fw[i] = $urandom;
                        exp_q.push_back({3'(i), fw[i]});
                    end
                    send_frame(fw);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        wait_words(80, 200);
        n_tests++;
        if (got_q.size() != 80) begin
            $display("FAIL rand_count got %0d want 80", got_q.size());
            n_fail++;
        end
        for (int k = 0; k < 80 && k < got_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin
                $display("FAIL rand_word%0d got %h want %h",
                         k, got_q[k], exp_q[k]);
                n_fail++;
            end
        end
        n_tests++;
        if (stab_err != 0) begin
            $display("FAIL rand_stable got %0d changes want 0", stab_err);
            n_fail++;
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            $display("FAIL rand_overflow got %b want 0", overflow);
            n_fail++;
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        stab_err  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bits   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_gapped();
        test_overflow();
        test_simul_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
